// File: rtl/w_stage_grf.sv
// Write-back stage and 32x32 general register file: decodes the W-stage
// instruction, extends load data, commits to the array and serves both D-stage reads.
module w_stage_grf #(
  parameter bit BYPASS_EN = 1'b1,
  parameter int CNT_W     = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [31:0]      IMcode_W,
  input  logic [31:0]      PC_W,
  input  logic [31:0]      AO_W,
  input  logic [31:0]      DO_W,
  input  logic [4:0]       A1,
  input  logic [4:0]       A2,
  output logic [31:0]      RD1,
  output logic [31:0]      RD2,
  output logic             WE_W,
  output logic [4:0]       A3_W,
  output logic [31:0]      WD_W,
  output logic [CNT_W-1:0] Retired
);

  logic [31:0]      r_regs [32];
  logic [CNT_W-1:0] r_retired;

  logic [5:0]  w_op;
  logic [5:0]  w_fn;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [31:0] w_pc8;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_wr;
  logic [4:0]  w_a3;
  logic [31:0] w_wd;
  logic        w_unused_bits;

  assign w_op  = IMcode_W[31:26];
  assign w_fn  = IMcode_W[5:0];
  assign w_rt  = IMcode_W[20:16];
  assign w_rd  = IMcode_W[15:11];
  assign w_pc8 = PC_W + 32'd8;
  assign w_unused_bits = ^{IMcode_W[25:21], IMcode_W[10:6]};

  always_comb begin
    w_byte = DO_W[7:0];
    case (AO_W[1:0])
      2'd1:    w_byte = DO_W[15:8];
      2'd2:    w_byte = DO_W[23:16];
      2'd3:    w_byte = DO_W[31:24];
      default: w_byte = DO_W[7:0];
    endcase
  end

  // Halfword alignment uses AO_W[1] only; AO_W[0] is deliberately ignored.
  assign w_half = AO_W[1] ? DO_W[31:16] : DO_W[15:0];

  always_comb begin
    w_wr = 1'b0;
    w_a3 = 5'd0;
    w_wd = 32'd0;
    case (w_op)
      6'h00: begin
        case (w_fn)
          6'h21, 6'h23, 6'h00: begin
            w_wr = 1'b1;
            w_a3 = w_rd;
            w_wd = AO_W;
          end
          6'h09: begin
            w_wr = 1'b1;
            w_a3 = w_rd;
            w_wd = w_pc8;
          end
          default: ;
        endcase
      end
      6'h0d, 6'h0f: begin
        w_wr = 1'b1;
        w_a3 = w_rt;
        w_wd = AO_W;
      end
      6'h23: begin
        w_wr = 1'b1;
        w_a3 = w_rt;
        w_wd = DO_W;
      end
      6'h20: begin
        w_wr = 1'b1;
        w_a3 = w_rt;
        w_wd = {{24{w_byte[7]}}, w_byte};
      end
      6'h24: begin
        w_wr = 1'b1;
        w_a3 = w_rt;
        w_wd = {24'd0, w_byte};
      end
      6'h21: begin
        w_wr = 1'b1;
        w_a3 = w_rt;
        w_wd = {{16{w_half[15]}}, w_half};
      end
      6'h25: begin
        w_wr = 1'b1;
        w_a3 = w_rt;
        w_wd = {16'd0, w_half};
      end
      6'h03: begin
        w_wr = 1'b1;
        w_a3 = 5'd31;
        w_wd = w_pc8;
      end
      default: ;
    endcase
  end

  assign WE_W = w_wr && (w_a3 != 5'd0);
  assign A3_W = w_a3;
  assign WD_W = w_wd;

  // Entry 0 is only ever cleared, so the array itself keeps $0 at zero.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= 32'd0;
    end else if (WE_W) begin
      r_regs[A3_W] <= WD_W;
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_retired <= '0;
    end else if (IMcode_W != 32'd0) begin
      r_retired <= r_retired + CNT_W'(1);
    end
  end

  assign Retired = r_retired;

  assign RD1 = (A1 == 5'd0) ? 32'd0 :
               (BYPASS_EN && WE_W && (A1 == A3_W)) ? WD_W : r_regs[A1];
  assign RD2 = (A2 == 5'd0) ? 32'd0 :
               (BYPASS_EN && WE_W && (A2 == A3_W)) ? WD_W : r_regs[A2];

endmodule

// File: tb/tb_w_stage_grf.sv
// Scoreboard bench for w_stage_grf: a bypassing 32-bit-counter instance and a
// non-bypassing instance with a 2-bit counter share all inputs.
module tb_w_stage_grf;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [31:0] IMcode_W, PC_W, AO_W, DO_W;
  logic [4:0]  A1, A2;
  logic [31:0] RD1, RD2, WD_W;
  logic        WE_W;
  logic [4:0]  A3_W;
  logic [31:0] Retired;
  logic [31:0] nb_rd1, nb_rd2, nb_wd;
  logic        nb_we;
  logic [4:0]  nb_a3;
  logic [1:0]  nb_ret;

  w_stage_grf u_dut (
    .CLK(CLK), .Reset(Reset), .IMcode_W(IMcode_W), .PC_W(PC_W), .AO_W(AO_W),
    .DO_W(DO_W), .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2), .WE_W(WE_W),
    .A3_W(A3_W), .WD_W(WD_W), .Retired(Retired)
  );

  w_stage_grf #(.BYPASS_EN(1'b0), .CNT_W(2)) u_nb (
    .CLK(CLK), .Reset(Reset), .IMcode_W(IMcode_W), .PC_W(PC_W), .AO_W(AO_W),
    .DO_W(DO_W), .A1(A1), .A2(A2), .RD1(nb_rd1), .RD2(nb_rd2), .WE_W(nb_we),
    .A3_W(nb_a3), .WD_W(nb_wd), .Retired(nb_ret)
  );

  always #5 CLK = ~CLK;

  typedef enum int {S_RD1, S_RD2, S_WE, S_A3, S_WD, S_RET, S_NB_RD1, S_NB_RET} sel_t;
  typedef struct {
    string       name;
    sel_t        sel;
    logic [31:0] exp;
  } chk_t;

  chk_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned exp_ret = 0;

  // Monitor: pops each expectation and compares against the current DUT outputs.
  initial begin
    chk_t        it;
    logic [31:0] act;
    forever begin
      wait (q.size() != 0);
      it = q.pop_front();
      case (it.sel)
        S_RD1:    act = RD1;
        S_RD2:    act = RD2;
        S_WE:     act = {31'd0, WE_W};
        S_A3:     act = {27'd0, A3_W};
        S_WD:     act = WD_W;
        S_RET:    act = Retired;
        S_NB_RD1: act = nb_rd1;
        default:  act = {30'd0, nb_ret};
      endcase
      checks++;
      if (act !== it.exp) begin
        errors++;
        $display("FAIL %s: got %08h expected %08h", it.name, act, it.exp);
      end
    end
  end

  task automatic expect_val(input string name, input sel_t sel, input logic [31:0] exp);
    chk_t it;
    it.name = name;
    it.sel  = sel;
    it.exp  = exp;
    q.push_back(it);
    fork
      wait (q.size() == 0);
      #3;
    join_any
    disable fork;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s: monitor never consumed the expectation", name);
      q.delete();
    end
  endtask

  task automatic clk_edge();
    if (Reset && IMcode_W != 32'd0) exp_ret++;
    @(posedge CLK);
    #2;
  endtask

  task automatic set_w(input logic [31:0] ir, input logic [31:0] pc,
                       input logic [31:0] ao, input logic [31:0] dout);
    IMcode_W = ir;
    PC_W     = pc;
    AO_W     = ao;
    DO_W     = dout;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b0;
    A1 = 5'd5;
    A2 = 5'd31;
    set_w(32'd0, 32'd0, 32'd0, 32'd0);
    expect_val("rst_rd1", S_RD1, 32'd0);
    expect_val("rst_rd2", S_RD2, 32'd0);
    expect_val("rst_ret", S_RET, 32'd0);
    Reset = 1'b1;
    #1;
    expect_val("post_rst_rd1", S_RD1, 32'd0);
    expect_val("post_rst_rd2", S_RD2, 32'd0);
    clk_edge();
    expect_val("bubble_ret", S_RET, 32'd0);

    // lui $1
    set_w(32'h3C01_1234, 32'h0000_3000, 32'h1234_0000, 32'd0);
    expect_val("lui_we", S_WE, 32'd1);
    expect_val("lui_a3", S_A3, 32'd1);
    expect_val("lui_wd", S_WD, 32'h1234_0000);
    clk_edge();

    // addu $3,$1,$2 with same-cycle read of $3
    A1 = 5'd1;
    set_w(32'h0022_1821, 32'h0000_3004, 32'hDEAD_BEEF, 32'd0);
    expect_val("lui_commit", S_RD1, 32'h1234_0000);
    expect_val("ret_one", S_RET, 32'd1);
    A1 = 5'd3;
    #1;
    expect_val("bypass_rd1", S_RD1, 32'hDEAD_BEEF);
    expect_val("nobypass_rd1", S_NB_RD1, 32'd0);
    clk_edge();
    set_w(32'd0, 32'd0, 32'd0, 32'd0);
    expect_val("addu_commit", S_RD1, 32'hDEAD_BEEF);
    expect_val("addu_commit_nb", S_NB_RD1, 32'hDEAD_BEEF);
    expect_val("ret_two", S_RET, 32'd2);
    clk_edge();
    expect_val("bubble_no_count", S_RET, 32'd2);

    // Sub-word loads into $4
    A2 = 5'd4;
    set_w(32'h8004_0000, 32'd0, 32'h0000_0002, 32'h80FF_7F01);
    expect_val("lb_b2", S_WD, 32'hFFFF_FFFF);
    AO_W = 32'h0000_0003;
    #1;
    expect_val("lb_b3", S_WD, 32'hFFFF_FF80);
    AO_W = 32'h0000_0002;
    clk_edge();
    expect_val("lb_commit", S_RD2, 32'hFFFF_FFFF);
    set_w(32'h9004_0000, 32'd0, 32'h0000_0002, 32'h80FF_7F01);
    expect_val("lbu_b2", S_WD, 32'h0000_00FF);
    AO_W = 32'h0000_0001;
    #1;
    expect_val("lbu_b1", S_WD, 32'h0000_007F);
    AO_W = 32'h0000_0002;
    clk_edge();
    expect_val("lbu_commit", S_RD2, 32'h0000_00FF);
    set_w(32'h8404_0000, 32'd0, 32'h0000_0003, 32'h80FF_7F01);
    expect_val("lh_hi_ao0_ignored", S_WD, 32'hFFFF_80FF);
    clk_edge();
    expect_val("lh_commit", S_RD2, 32'hFFFF_80FF);
    set_w(32'h9404_0000, 32'd0, 32'h0000_0001, 32'h80FF_7F01);
    expect_val("lhu_lo", S_WD, 32'h0000_7F01);
    clk_edge();
    A1 = 5'd4;
    #1;
    expect_val("same_addr_rd1", S_RD1, 32'h0000_7F01);
    expect_val("same_addr_rd2", S_RD2, 32'h0000_7F01);

    // jal / jalr with PC wrap
    A2 = 5'd31;
    set_w(32'h0C00_0000, 32'h0000_3010, 32'd0, 32'd0);
    expect_val("jal_a3", S_A3, 32'd31);
    expect_val("jal_wd", S_WD, 32'h0000_3018);
    clk_edge();
    expect_val("jal_commit", S_RD2, 32'h0000_3018);
    set_w(32'h0000_F809, 32'hFFFF_FFFC, 32'd0, 32'd0);
    expect_val("jalr_wrap", S_WD, 32'h0000_0004);
    clk_edge();
    expect_val("jalr_commit", S_RD2, 32'h0000_0004);

    // Write to $0 suppressed
    A1 = 5'd0;
    set_w(32'h0022_0021, 32'd0, 32'hCAFE_F00D, 32'd0);
    expect_val("rd0_we", S_WE, 32'd0);
    expect_val("rd0_rd1", S_RD1, 32'd0);
    clk_edge();
    expect_val("r0_after", S_RD1, 32'd0);

    // sw: no write, still retires
    set_w(32'hAC01_0000, 32'd0, 32'h0000_0010, 32'd0);
    expect_val("sw_we", S_WE, 32'd0);
    expect_val("sw_a3", S_A3, 32'd0);
    expect_val("sw_wd", S_WD, 32'd0);
    clk_edge();
    expect_val("sw_ret", S_RET, exp_ret);
    expect_val("nb_ret_wrap", S_NB_RET, exp_ret & 32'd3);

    // ori $7 = 0x55, then async reset with a lw $7 in flight
    A1 = 5'd7;
    set_w(32'h3407_0055, 32'd0, 32'h0000_0055, 32'd0);
    clk_edge();
    set_w(32'd0, 32'd0, 32'd0, 32'd0);
    expect_val("ori_commit", S_RD1, 32'h0000_0055);
    set_w(32'h8C07_0000, 32'd0, 32'd0, 32'h1234_5678);
    expect_val("lw_bypass", S_RD1, 32'h1234_5678);
    expect_val("lw_nb_old", S_NB_RD1, 32'h0000_0055);
    Reset = 1'b0;
    exp_ret = 0;
    #1;
    expect_val("async_clear_nb", S_NB_RD1, 32'd0);
    expect_val("async_rd1_bypass", S_RD1, 32'h1234_5678);
    expect_val("async_ret", S_RET, 32'd0);
    clk_edge();
    expect_val("held_rst_ret", S_RET, 32'd0);
    expect_val("held_rst_nb", S_NB_RD1, 32'd0);
    set_w(32'd0, 32'd0, 32'd0, 32'd0);
    Reset = 1'b1;
    #1;
    expect_val("lw_discarded", S_RD1, 32'd0);
    set_w(32'h8C07_0000, 32'd0, 32'd0, 32'h1234_5678);
    clk_edge();
    set_w(32'd0, 32'd0, 32'd0, 32'd0);
    expect_val("resume_commit", S_RD1, 32'h1234_5678);
    expect_val("resume_ret", S_RET, exp_ret);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
